// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller of the asynchronous FIFO.
// Owns the binary/Gray write pointer and derives full, almost-full, level and overflow.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH     = 4,
    parameter int ALMOST_FULL_TH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH:0]   i_rd_ptr_gray_sync,
    input  logic                  i_clr_overflow,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [ADDR_WIDTH:0]   o_wr_ptr_gray,
    output logic                  o_full,
    output logic                  o_almost_full,
    output logic [ADDR_WIDTH:0]   o_wr_level,
    output logic                  o_overflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);

    logic [PW-1:0] wbin_reg;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_reg;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] level_reg;
    logic [PW-1:0] level_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_cmp;
    logic          full_reg;
    logic          full_next;
    logic          af_reg;
    logic          af_next;
    logic          ovf_reg;
    logic          ovf_next;
    logic          accept;

    // Each binary bit is the XOR of all Gray bits from the MSB down to it;
    // written as independent reductions so there is no ripple chain.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign rbin[gi] = ^i_rd_ptr_gray_sync[PW-1:gi];
        end
    endgenerate

    // Write pointer one lap ahead of the read pointer: top two Gray bits inverted.
    assign full_cmp = {~i_rd_ptr_gray_sync[PW-1],
                       ~i_rd_ptr_gray_sync[PW-2],
                        i_rd_ptr_gray_sync[PW-3:0]};

    always_comb begin
        accept     = i_wr_en & ~full_reg;
        wbin_next  = wbin_reg + {{(PW-1){1'b0}}, accept};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        full_next  = (wgray_next == full_cmp);
        level_next = wbin_next - rbin;
        af_next    = (level_next >= AF_TH);
        ovf_next   = ovf_reg;
        if (i_clr_overflow) begin
            ovf_next = 1'b0;
        end
        // A rejected write on the same edge as a clear still leaves the flag set.
        if (i_wr_en & full_reg) begin
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wbin_reg  <= '0;
            wgray_reg <= '0;
            level_reg <= '0;
            full_reg  <= 1'b0;
            af_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            wbin_reg  <= wbin_next;
            wgray_reg <= wgray_next;
            level_reg <= level_next;
            full_reg  <= full_next;
            af_reg    <= af_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign o_mem_wr_en   = accept;
    assign o_wr_addr     = wbin_reg[ADDR_WIDTH-1:0];
    assign o_wr_ptr_gray = wgray_reg;
    assign o_full        = full_reg;
    assign o_almost_full = af_reg;
    assign o_wr_level    = level_reg;
    assign o_overflow    = ovf_reg;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: expected snapshots are queued when a cycle
// is driven and compared once the DUT has taken the edge.
module tb_fifo_wr_ctrl;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [PW-1:0] gray;
        logic          full;
        logic          af;
        logic [PW-1:0] level;
        logic          ovf;
    } snap_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [PW-1:0] rq;
    logic          clr_ovf;
    logic          mem_wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_gray;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wr_level;
    logic          overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    snap_t         sb_q[$];
    logic [PW-1:0] m_wbin;
    logic          m_full;
    logic          m_ovf;
    logic [PW-1:0] g_prev;

    always #5 clk = ~clk;

    fifo_wr_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_wr_en            (wr_en),
        .i_rd_ptr_gray_sync (rq),
        .i_clr_overflow     (clr_ovf),
        .o_mem_wr_en        (mem_wr_en),
        .o_wr_addr          (wr_addr),
        .o_wr_ptr_gray      (wr_gray),
        .o_full             (full),
        .o_almost_full      (almost_full),
        .o_wr_level         (wr_level),
        .o_overflow         (overflow)
    );

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic snap_t sample_dut();
        snap_t s;
        s.addr  = wr_addr;
        s.gray  = wr_gray;
        s.full  = full;
        s.af    = almost_full;
        s.level = wr_level;
        s.ovf   = overflow;
        return s;
    endfunction

    // Drives one cycle, pushes the model's expectation, and returns #1 after the edge.
    task automatic drive_cycle(input logic wr, input logic [PW-1:0] rptr_bin, input logic clr);
        snap_t         e;
        logic          acc;
        logic [PW-1:0] nb;
        logic [PW-1:0] lvl;
        wr_en   = wr;
        rq      = to_gray(rptr_bin);
        clr_ovf = clr;
        acc     = wr & ~m_full;
        nb      = m_wbin + PW'(acc);
        lvl     = nb - rptr_bin;
        e.addr  = nb[AW-1:0];
        e.gray  = to_gray(nb);
        e.full  = (lvl == PW'(DEPTH));
        e.af    = (lvl >= PW'(AF));
        e.level = lvl;
        e.ovf   = (wr & m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_wbin  = nb;
        m_full  = e.full;
        m_ovf   = e.ovf;
        sb_q.push_back(e);
        g_prev  = wr_gray;
        @(posedge clk);
        #1;
        $display("[TB] txn wr=%0b rbin=%0d clr=%0b -> addr=%0d gray=%b lvl=%0d full=%0b af=%0b ovf=%0b",
                 wr, rptr_bin, clr, wr_addr, wr_gray, wr_level, full, almost_full, overflow);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        rq      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_wbin  = '0;
        m_full  = 1'b0;
        m_ovf   = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t got;
        rst_n = 1'b0;
        wr_en = 1'b1;
        rq    = '0;
        #2;
        got = sample_dut();
        tests_run++;
        if (got !== '0) begin
            tests_failed++;
            $display("FAIL reset_state actual=%h required=0", got);
        end
        tests_run++;
        if (mem_wr_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mem_wr_en actual=%b required=1", mem_wr_en);
        end
        apply_reset();
        got = sample_dut();
        tests_run++;
        if (got !== '0) begin
            tests_failed++;
            $display("FAIL reset_release actual=%h required=0", got);
        end
    endtask

    task automatic test_fill();
        snap_t exp_s;
        snap_t got;
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, '0, 1'b0);
            exp_s = sb_q.pop_front();
            got   = sample_dut();
            tests_run++;
            if (got !== exp_s) begin
                tests_failed++;
                $display("FAIL fill_write%0d actual=%h required=%h", i, got, exp_s);
            end
        end
        tests_run++;
        if (full !== 1'b1 || wr_gray !== 5'b11000 || wr_level !== 5'd16 || wr_addr !== 4'd0) begin
            tests_failed++;
            $display("FAIL fill_final actual full=%b gray=%b lvl=%0d addr=%0d required 1/11000/16/0",
                     full, wr_gray, wr_level, wr_addr);
        end
        wr_en = 1'b1;
        #1;
        tests_run++;
        if (mem_wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_blocks_wr actual=%b required=0", mem_wr_en);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow();
        snap_t exp_s;
        snap_t got;
        drive_cycle(1'b1, '0, 1'b0);
        exp_s = sb_q.pop_front();
        got   = sample_dut();
        tests_run++;
        if (got !== exp_s || overflow !== 1'b1 || wr_gray !== 5'b11000) begin
            tests_failed++;
            $display("FAIL overflow_set actual=%h required=%h (ovf=1 gray=11000)", got, exp_s);
        end
        drive_cycle(1'b0, '0, 1'b1);
        exp_s = sb_q.pop_front();
        got   = sample_dut();
        tests_run++;
        if (got !== exp_s || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_clear actual=%h required=%h", got, exp_s);
        end
        drive_cycle(1'b1, '0, 1'b1);
        exp_s = sb_q.pop_front();
        got   = sample_dut();
        tests_run++;
        if (got !== exp_s || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_set_wins actual=%h required=%h", got, exp_s);
        end
        drive_cycle(1'b0, '0, 1'b1);
        exp_s = sb_q.pop_front();
        got   = sample_dut();
        tests_run++;
        if (got !== exp_s) begin
            tests_failed++;
            $display("FAIL overflow_clear2 actual=%h required=%h", got, exp_s);
        end
    endtask

    task automatic test_read_advance();
        snap_t exp_s;
        snap_t got;
        drive_cycle(1'b0, 5'd1, 1'b0);
        exp_s = sb_q.pop_front();
        got   = sample_dut();
        tests_run++;
        if (got !== exp_s || full !== 1'b0 || wr_level !== 5'd15 || almost_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_advance actual=%h required=%h (full=0 lvl=15 af=1)", got, exp_s);
        end
    endtask

    task automatic test_almost_full();
        snap_t exp_s;
        snap_t got;
        apply_reset();
        for (int i = 0; i < AF; i++) begin
            drive_cycle(1'b1, '0, 1'b0);
            exp_s = sb_q.pop_front();
            got   = sample_dut();
            tests_run++;
            if (got !== exp_s) begin
                tests_failed++;
                $display("FAIL af_write%0d actual=%h required=%h", i, got, exp_s);
            end
            if (i == AF - 2) begin
                tests_run++;
                if (almost_full !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL af_below_th actual=%b required=0", almost_full);
                end
            end
        end
        tests_run++;
        if (almost_full !== 1'b1 || wr_level !== 5'd12) begin
            tests_failed++;
            $display("FAIL af_at_th actual af=%b lvl=%0d required af=1 lvl=12", almost_full, wr_level);
        end
    endtask

    task automatic test_wrap();
        snap_t exp_s;
        snap_t got;
        apply_reset();
        for (int lap = 0; lap < 2; lap++) begin
            for (int i = 0; i < DEPTH; i++) begin
                drive_cycle(1'b1, (lap == 0) ? 5'd0 : 5'd16, 1'b0);
                exp_s = sb_q.pop_front();
                got   = sample_dut();
                tests_run++;
                if (got !== exp_s || $countones(g_prev ^ wr_gray) != 1) begin
                    tests_failed++;
                    $display("FAIL wrap_lap%0d_w%0d actual=%h required=%h prev_gray=%b",
                             lap, i, got, exp_s, g_prev);
                end
            end
            if (lap == 0) begin
                drive_cycle(1'b0, 5'd16, 1'b0);
                exp_s = sb_q.pop_front();
                got   = sample_dut();
                tests_run++;
                if (got !== exp_s || wr_level !== 5'd0 || full !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL wrap_drain actual=%h required=%h (lvl=0)", got, exp_s);
                end
            end
        end
        tests_run++;
        if (full !== 1'b1 || wr_gray !== 5'b00000) begin
            tests_failed++;
            $display("FAIL wrap_full actual full=%b gray=%b required 1/00000", full, wr_gray);
        end
    endtask

    task automatic test_back_to_back();
        snap_t exp_s;
        snap_t got;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, '0, 1'b0);
            void'(sb_q.pop_front());
        end
        for (int i = 1; i <= 10; i++) begin
            drive_cycle(1'b1, PW'(i), 1'b0);
            exp_s = sb_q.pop_front();
            got   = sample_dut();
            tests_run++;
            if (got !== exp_s || wr_level !== 5'd8) begin
                tests_failed++;
                $display("FAIL b2b_%0d actual=%h required=%h (lvl=8)", i, got, exp_s);
            end
        end
    endtask

    task automatic test_async_reset();
        snap_t exp_s;
        snap_t got;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, '0, 1'b0);
            void'(sb_q.pop_front());
        end
        wr_en = 1'b1;
        rq    = '0;
        #2;
        rst_n = 1'b0;
        #1;
        got = sample_dut();
        tests_run++;
        if (got !== '0 || mem_wr_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset actual=%h mem_wr_en=%b required=0 / 1", got, mem_wr_en);
        end
        wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_wbin = '0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        tests_run++;
        if (wr_addr !== 4'd0) begin
            tests_failed++;
            $display("FAIL post_reset_addr actual=%0d required=0", wr_addr);
        end
        drive_cycle(1'b1, '0, 1'b0);
        exp_s = sb_q.pop_front();
        got   = sample_dut();
        tests_run++;
        if (got !== exp_s || wr_gray !== 5'b00001) begin
            tests_failed++;
            $display("FAIL post_reset_write actual=%h required=%h (gray=00001)", got, exp_s);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rq      = '0;
        clr_ovf = 1'b0;
        m_wbin  = '0;
        m_full  = 1'b0;
        m_ovf   = 1'b0;
        g_prev  = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_read_advance();
        test_almost_full();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
